ifu: RTL

Instruction fetch unit of the five-stage MIPS core: holds the architectural PC, drives the fetch address into the instruction memory, captures the returned instruction into the IF/ID pipeline register, and computes the next PC from the D-stage control decision. It sits between the hazard/decode logic (stall, next-PC select, `jr` operand) and the instruction memory (`f_pc` out, `f_instr` back). MIPS delay-slot semantics apply: a taken branch or jump never squashes the instruction already in F.

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu_npc.sv | 42 ++++
 rtl/ifu.sv | 62 ++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction fetch unit.
//   PC_INIT  - architectural reset PC
//   IM_MAX   - instruction memory depth in 32-bit words
//   PC_END   - first byte address past instruction memory
//   npc_sel_t - D-stage next-PC select encodings (shared with decode)
//   pc_err   - misalignment / out-of-range check for a fetch address
package ifu_pkg;

    localparam logic [31:0] PC_INIT = 32'h0000_3000;
    localparam int unsigned IM_MAX  = 1024;
    localparam logic [31:0] PC_END  = PC_INIT + 32'(4 * IM_MAX);

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_t;

    // True when pc is not word aligned or falls outside [PC_INIT, PC_END).
    function automatic logic pc_err(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < PC_INIT) || (pc >= PC_END);
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// ifu_npc: combinational next-PC computation.
//   f_pc    in  32 - current fetch address
//   d_pc    in  32 - PC of the instruction in D
//   d_instr in  32 - instruction in D (branch offset / jump index source)
//   rs_val  in  32 - forwarded rs value for jr/jalr
//   npc_sel in  2  - next-PC select from decode
//   npc     out 32 - next PC
// All arithmetic wraps modulo 2^32.
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic [31:0] rs_val,
    input  logic [1:0]  npc_sel,
    output logic [31:0] npc
);

    logic [31:0] d_pc4;
    logic [31:0] br_off;
    logic        unused_opcode;

    assign d_pc4  = d_pc + 32'd4;
    // Sign-extended 16-bit word offset converted to a byte offset.
    assign br_off = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
    // Opcode bits play no part in target formation.
    assign unused_opcode = ^d_instr[31:26];

    always_comb begin
        npc = f_pc + 32'd4;
        case (npc_sel_t'(npc_sel))
            NPC_PC4: npc = f_pc + 32'd4;
            NPC_BR:  npc = d_pc4 + br_off;
            // Region bits come from the delay-slot address, i.e. d_pc + 4.
            NPC_J:   npc = {d_pc4[31:28], d_instr[25:0], 2'b00};
            NPC_JR:  npc = rs_val;
            default: npc = f_pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit of the five-stage MIPS core.
// Holds the PC register and the IF/ID pipeline register. The instruction
// in F always proceeds to D on a non-stalled edge (delay slot), and the
// redirect target chosen from the D-stage instruction is fetched next.
//   clk      in  1  - clock, rising edge
//   rst_n    in  1  - asynchronous active-low reset
//   stall    in  1  - freeze PC and IF/ID
//   npc_sel  in  2  - next-PC select (PC+4 / branch / j / jr)
//   rs_val   in  32 - forwarded jr target
//   f_pc     out 32 - fetch address (registered)
//   f_instr  in  32 - instruction returned combinationally for f_pc
//   f_pc_err out 1  - f_pc misaligned or outside instruction memory
//   d_instr  out 32 - IF/ID instruction
//   d_pc     out 32 - IF/ID PC
//   d_valid  out 1  - IF/ID holds a fetched instruction
module ifu
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] rs_val,
    output logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    output logic        f_pc_err,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic        d_valid
);

    logic [31:0] npc;

    ifu_npc u_npc (
        .f_pc    (f_pc),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .rs_val  (rs_val),
        .npc_sel (npc_sel),
        .npc     (npc)
    );

    // Stall has priority over any redirect: the D instruction is held, so
    // the same redirect is re-evaluated once the stall clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc    <= PC_INIT;
            d_instr <= '0;
            d_pc    <= '0;
            d_valid <= 1'b0;
        end else if (!stall) begin
            f_pc    <= npc;
            d_instr <= f_instr;
            d_pc    <= f_pc;
            d_valid <= 1'b1;
        end
    end

    // Flag only; fetch proceeds and exception logic decides what to do.
    assign f_pc_err = pc_err(f_pc);

endmodule
